// File: rtl/race_scroll_pkg.sv
// Shared game package: race FSM state encoding, Q8.4 speed type and
// saturating speed arithmetic used by the race scroller.
package race_scroll_pkg;

    localparam int SPEED_W = 12;
    localparam int ACC_W   = 36;

    typedef logic [SPEED_W-1:0] speed_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACE      = 2'd2,
        ST_FINISHED  = 2'd3
    } race_state_e;

    function automatic speed_t subFloor(input speed_t a, input speed_t b);
        return (a >= b) ? speed_t'(a - b) : '0;
    endfunction

    // Extra carry bit so a sum past the top of the Q8.4 range still clamps.
    function automatic speed_t addSat(input speed_t a, input speed_t b, input speed_t limit);
        logic [SPEED_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, limit}) ? limit : sum[SPEED_W-1:0];
    endfunction

endpackage

// File: rtl/race_scroll_frame_tick_gen.sv
// Frame tick generator: one-cycle registered pulse the cycle after a rising
// vblnk_in is sampled.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vblnk_i,
    output logic tick_o
);

    logic vblnk_q;
    logic tick_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vblnk_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            vblnk_q <= vblnk_i;
            tick_q  <= vblnk_i & ~vblnk_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/race_scroll.sv
// Race scroller: countdown / race / finish FSM with Q8.4 speed physics and a
// Q32.4 scroll accumulator, all updated once per frame tick.
module race_scroll
    import race_scroll_pkg::*;
#(
    parameter logic [31:0] FINISH_POS       = 32'd1180,
    parameter logic [7:0]  COUNTDOWN_FRAMES = 8'd180,
    parameter speed_t      ACCEL            = 12'd2,
    parameter speed_t      BRAKE_DECEL      = 12'd8,
    parameter speed_t      DRAG             = 12'd1,
    parameter speed_t      MAX_SPEED        = 12'h100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vblnk_in,
    input  logic               start,
    input  logic               throttle,
    input  logic               brake,
    output logic [31:0]        position,
    output logic [SPEED_W-1:0] speed,
    output logic [1:0]         state,
    output logic [7:0]         countdown,
    output logic [15:0]        race_time,
    output logic               finished,
    output logic               false_start
);

    logic tick;

    frame_tick_gen u_tick (
        .clk     (clk),
        .reset   (reset),
        .vblnk_i (vblnk_in),
        .tick_o  (tick)
    );

    race_state_e       state_q, state_d;
    speed_t            speed_q, speed_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [7:0]        countdown_q, countdown_d;
    logic [15:0]       race_time_q, race_time_d;
    logic              finished_q, finished_d;
    logic              false_start_q, false_start_d;
    logic [ACC_W-1:0]  acc_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            speed_q       <= '0;
            acc_q         <= '0;
            countdown_q   <= '0;
            race_time_q   <= '0;
            finished_q    <= 1'b0;
            false_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            speed_q       <= speed_d;
            acc_q         <= acc_d;
            countdown_q   <= countdown_d;
            race_time_q   <= race_time_d;
            finished_q    <= finished_d;
            false_start_q <= false_start_d;
        end
    end

    // The accumulator always advances by the speed held before this tick's update.
    assign acc_sum = acc_q + {{(ACC_W-SPEED_W){1'b0}}, speed_q};

    always_comb begin
        state_d       = state_q;
        speed_d       = speed_q;
        acc_d         = acc_q;
        countdown_d   = countdown_q;
        race_time_d   = race_time_q;
        finished_d    = finished_q;
        false_start_d = false_start_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_COUNTDOWN;
                    countdown_d = COUNTDOWN_FRAMES;
                end
            end

            ST_COUNTDOWN: begin
                if (tick) begin
                    if (throttle) begin
                        false_start_d = 1'b1;
                    end
                    if (countdown_q <= 8'd1) begin
                        countdown_d = 8'd0;
                        state_d     = ST_RACE;
                    end else begin
                        countdown_d = countdown_q - 8'd1;
                    end
                end
            end

            ST_RACE: begin
                if (tick) begin
                    acc_d = acc_sum;
                    if (brake) begin
                        speed_d = subFloor(speed_q, BRAKE_DECEL);
                    end else if (throttle) begin
                        speed_d = addSat(speed_q, ACCEL, MAX_SPEED);
                    end else begin
                        speed_d = subFloor(speed_q, DRAG);
                    end
                    if (race_time_q != 16'hFFFF) begin
                        race_time_d = race_time_q + 16'd1;
                    end
                    if (acc_sum[ACC_W-1:4] >= FINISH_POS) begin
                        state_d    = ST_FINISHED;
                        finished_d = 1'b1;
                    end
                end
            end

            ST_FINISHED: begin
                if (start) begin
                    state_d       = ST_IDLE;
                    speed_d       = '0;
                    acc_d         = '0;
                    countdown_d   = '0;
                    race_time_d   = '0;
                    finished_d    = 1'b0;
                    false_start_d = 1'b0;
                end else if (tick) begin
                    acc_d   = acc_sum;
                    speed_d = subFloor(speed_q, BRAKE_DECEL);
                end
            end
        endcase
    end

    assign position    = acc_q[ACC_W-1:4];
    assign speed       = speed_q;
    assign state       = state_q;
    assign countdown   = countdown_q;
    assign race_time   = race_time_q;
    assign finished    = finished_q;
    assign false_start = false_start_q;

endmodule

// File: tb/tb_race_scroll.sv
// Directed bench for race_scroll: a long-track instance and a FINISH_POS=5
// instance share the same stimulus.
module tb_race_scroll;

    logic clk = 1'b0;
    logic reset, vblnk_in, start, throttle, brake;

    logic [31:0] posA, posB;
    logic [11:0] speedA, speedB;
    logic [1:0]  stateA, stateB;
    logic [7:0]  cdA, cdB;
    logic [15:0] rtA, rtB;
    logic        finA, finB, fsA, fsB;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    race_scroll #(.FINISH_POS(32'd100000)) dutA (
        .clk(clk), .reset(reset), .vblnk_in(vblnk_in), .start(start),
        .throttle(throttle), .brake(brake), .position(posA), .speed(speedA),
        .state(stateA), .countdown(cdA), .race_time(rtA),
        .finished(finA), .false_start(fsA)
    );

    race_scroll #(.FINISH_POS(32'd5)) dutB (
        .clk(clk), .reset(reset), .vblnk_in(vblnk_in), .start(start),
        .throttle(throttle), .brake(brake), .position(posB), .speed(speedB),
        .state(stateB), .countdown(cdB), .race_time(rtB),
        .finished(finB), .false_start(fsB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // vblnk rises at a negedge, tick is high for the following cycle,
    // and outputs are sampled on the negedge after the tick is consumed.
    task automatic applyStimulus();
        @(negedge clk) vblnk_in = 1'b1;
        @(negedge clk) vblnk_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic checkAllZero(input string tag, input logic [1:0] st, input logic [31:0] pos,
                                input logic [11:0] spd, input logic [7:0] cd, input logic [15:0] rt,
                                input logic fin, input logic fs);
        checkOutput({tag, "_state"}, 32'(st), 0);
        checkOutput({tag, "_position"}, pos, 0);
        checkOutput({tag, "_speed"}, 32'(spd), 0);
        checkOutput({tag, "_countdown"}, 32'(cd), 0);
        checkOutput({tag, "_race_time"}, 32'(rt), 0);
        checkOutput({tag, "_finished"}, 32'(fin), 0);
        checkOutput({tag, "_false_start"}, 32'(fs), 0);
    endtask

    initial begin
        reset = 1'b1; vblnk_in = 1'b0; start = 1'b0; throttle = 1'b0; brake = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("resetA", stateA, posA, speedA, cdA, rtA, finA, fsA);

        // Start coincident with a tick: the tick must not decrement the countdown.
        @(negedge clk) vblnk_in = 1'b1;
        @(negedge clk) begin vblnk_in = 1'b0; start = 1'b1; end
        @(negedge clk) start = 1'b0;
        checkOutput("start_state", 32'(stateA), 1);
        checkOutput("start_countdown", 32'(cdA), 180);

        for (int i = 1; i <= 180; i++) begin
            applyStimulus();
            checkOutput("cd_count", 32'(cdA), 32'(180 - i));
            if (i == 90) begin
                pulseStart();
                checkOutput("cd_start_ignored_state", 32'(stateA), 1);
                checkOutput("cd_start_ignored_count", 32'(cdA), 90);
            end
            if (i == 179) checkOutput("cd_state_179", 32'(stateA), 1);
        end
        checkOutput("race_state", 32'(stateA), 2);
        checkOutput("race_false_start", 32'(fsA), 0);

        // Ten throttle ticks; dutB crosses its finish line on the tenth.
        throttle = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus();
            if (i == 9) begin
                checkOutput("B_pos_t9", posB, 4);
                checkOutput("B_state_t9", 32'(stateB), 2);
            end
        end
        checkOutput("A_speed_t10", 32'(speedA), 20);
        checkOutput("A_pos_t10", posA, 5);
        checkOutput("A_rt_t10", 32'(rtA), 10);
        checkOutput("B_state_t10", 32'(stateB), 3);
        checkOutput("B_finished_t10", 32'(finB), 1);
        checkOutput("B_rt_t10", 32'(rtB), 10);

        pulseStart();
        checkOutput("A_race_start_ignored", 32'(stateA), 2);
        checkOutput("B_finish_to_idle", 32'(stateB), 0);
        checkOutput("B_idle_finished", 32'(finB), 0);

        for (int i = 11; i <= 200; i++) begin
            applyStimulus();
            if (i == 127) checkOutput("A_speed_t127", 32'(speedA), 254);
            if (i == 128) begin
                checkOutput("A_speed_t128", 32'(speedA), 256);
                checkOutput("A_pos_t128", posA, 1016);
            end
        end
        checkOutput("A_speed_t200", 32'(speedA), 256);
        checkOutput("A_pos_t200", posA, 2168);
        checkOutput("A_rt_t200", 32'(rtA), 200);

        // Brake wins over throttle.
        brake = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            applyStimulus();
            checkOutput("A_brake_speed", 32'(speedA), (i >= 32) ? 0 : 32'(256 - 8 * i));
        end
        checkOutput("A_pos_brake", posA, 2432);
        checkOutput("A_rt_brake", 32'(rtA), 233);

        brake = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("A_speed_pre_reset", 32'(speedA), 6);
        checkOutput("A_state_pre_reset", 32'(stateA), 2);

        // Reset lands on the same edge that consumes a tick.
        @(negedge clk) vblnk_in = 1'b1;
        @(negedge clk) begin vblnk_in = 1'b0; reset = 1'b1; end
        @(negedge clk) reset = 1'b0;
        checkAllZero("midreset", stateA, posA, speedA, cdA, rtA, finA, fsA);
        applyStimulus();
        checkOutput("idle_speed_after_tick", 32'(speedA), 0);
        checkOutput("idle_state_after_tick", 32'(stateA), 0);

        // False start, finish, coasting in FINISHED, then back to IDLE.
        pulseStart();
        repeat (180) applyStimulus();
        checkOutput("B_false_start", 32'(fsB), 1);
        checkOutput("B_fs_state", 32'(stateB), 2);
        repeat (10) applyStimulus();
        checkOutput("B_fs_finished", 32'(finB), 1);
        checkOutput("B_fs_speed", 32'(speedB), 20);
        applyStimulus();
        checkOutput("B_coast_speed1", 32'(speedB), 12);
        checkOutput("B_coast_pos1", posB, 6);
        applyStimulus();
        checkOutput("B_coast_speed2", 32'(speedB), 4);
        checkOutput("B_coast_pos2", posB, 7);
        checkOutput("B_coast_rt", 32'(rtB), 10);
        pulseStart();
        checkAllZero("B_back_idle", stateB, posB, speedB, cdB, rtB, finB, fsB);
        checkOutput("A_still_race", 32'(stateA), 2);
        checkOutput("A_fs_flag", 32'(fsA), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
